// File: rtl/dac_setpoint_ctrl.sv
// ----------------------------------------------------------------------------
// dac_setpoint_ctrl
//
// Turns two push-buttons (up/down) into an 8-bit DAC set-point. It loads every
// new code into an external 8-bit serial DAC over a CS_N/SCLK/DIN link.
//
// Each button goes through three stages:
//   - a 2-flop synchroniser;
//   - a stability-counter debouncer;
//   - a rising-edge detector that produces a 1-cycle press pulse.
//
// Each press moves the code by STEP and saturates at 0x00 / 0xFF. A press
// that actually changes the code marks a reload as pending. The serial FSM
// then ships the latched code MSB first:
//   - din changes on SCLK falling edges;
//   - the DAC samples din on SCLK rising edges.
//
// Optional build macro: AUTO_REPEAT_EN
//   When defined, a held button generates extra press pulses. The first one
//   comes REPEAT_DELAY cycles after the press; the rest follow every
//   REPEAT_RATE cycles.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous reset, active-low
//   btn_up    in   raw up button, active-high, asynchronous to clk
//   btn_down  in   raw down button, active-high, asynchronous to clk
//   dac_val   out  [7:0] current DAC code (feeds the 7-segment display stage)
//   dac_cs_n  out  DAC chip select, active-low
//   dac_sclk  out  DAC serial clock, idle low
//   dac_din   out  DAC serial data, MSB first
//   busy      out  high while a serial transfer (including its CS_N
//                  high-hold) is in progress
// ----------------------------------------------------------------------------
module dac_setpoint_ctrl #(
    parameter logic [19:0] DEBOUNCE_CLK = 20'd1000000,
    parameter logic [7:0]  STEP         = 8'd1,
    parameter logic [7:0]  SCLK_DIV     = 8'd4
`ifdef AUTO_REPEAT_EN
    ,
    parameter logic [25:0] REPEAT_DELAY = 26'd50000000,
    parameter logic [25:0] REPEAT_RATE  = 26'd10000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] dac_val,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index 0 = up button, index 1 = down button.
    logic [1:0]  sync1, sync2;
    logic [1:0]  lvl, lvl_q;
    logic [19:0] db_cnt [2];
    logic [1:0]  press_edge;
    logic [1:0]  press;

    // ------------------------------------------------------------------------
    // Synchronise and debounce
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            lvl       <= '0;
            lvl_q     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {btn_down, btn_up};
            sync2 <= sync1;
            lvl_q <= lvl;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CLK - 20'd1) begin
                    lvl[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    assign press_edge = lvl & ~lvl_q;

`ifdef AUTO_REPEAT_EN
    // ------------------------------------------------------------------------
    // Auto-repeat
    //
    // rep_cnt counts cycles since the press pulse (phase 0) or since the last
    // repeat (phase 1). A hit re-arms the counter to 1 so that the next
    // REPEAT_RATE interval is measured from the repeat pulse itself. Hits
    // still re-arm while both buttons are held; only the pulse is suppressed.
    // ------------------------------------------------------------------------
    logic [25:0] rep_cnt [2];
    logic [1:0]  rep_phase;
    logic [1:0]  rep_hit;
    logic [1:0]  rep_pulse;

    always_comb begin
        rep_hit   = '0;
        rep_pulse = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            rep_hit[i]   = lvl[i] &&
                           (rep_phase[i] ? (rep_cnt[i] == REPEAT_RATE)
                                         : (rep_cnt[i] == REPEAT_DELAY));
            rep_pulse[i] = rep_hit[i] & ~(&lvl);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt[0] <= '0;
            rep_cnt[1] <= '0;
            rep_phase  <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (!lvl[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_hit[i]) begin
                    rep_cnt[i]   <= 26'd1;
                    rep_phase[i] <= 1'b1;
                end else begin
                    rep_cnt[i]   <= rep_cnt[i] + 26'd1;
                end
            end
        end
    end

    assign press = press_edge | rep_pulse;
`else
    assign press = press_edge;
`endif

    // ------------------------------------------------------------------------
    // Saturating code update
    // ------------------------------------------------------------------------
    logic       step_up, step_dn;
    logic [8:0] sum9, dif9;
    logic [7:0] val_nxt;
    logic       changed;
    logic       pending;
    logic       launch;

    always_comb begin
        step_up = press[0] & ~press[1];
        step_dn = press[1] & ~press[0];
        sum9    = {1'b0, dac_val} + {1'b0, STEP};
        dif9    = {1'b0, dac_val} - {1'b0, STEP};
        val_nxt = dac_val;
        if (step_up) begin
            val_nxt = sum9[8] ? 8'hFF : sum9[7:0];
        end else if (step_dn) begin
            // A borrow out of bit 8 means the result would go below zero.
            val_nxt = dif9[8] ? 8'h00 : dif9[7:0];
        end
        changed = (val_nxt != dac_val);
    end

    // A change in the same cycle as a launch must keep pending set: the
    // launch latched the old code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_val <= '0;
            pending <= 1'b1;
        end else begin
            dac_val <= val_nxt;
            pending <= changed | (pending & ~launch);
        end
    end

    // ------------------------------------------------------------------------
    // Serial transfer FSM
    //
    // shreg holds the bits still to be sent, MSB aligned. Bit 7 goes out on
    // din at launch; the rest follow on each falling SCLK edge.
    // ------------------------------------------------------------------------
    state_t      state, state_n;
    logic [7:0]  div_cnt, div_n;
    logic [3:0]  half_cnt, half_n;
    logic [7:0]  shreg, shreg_n;
    logic        cs_n_q, cs_n_n;
    logic        sclk_q, sclk_n;
    logic        din_q, din_n;
    logic        busy_q, busy_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            half_cnt <= half_n;
            shreg    <= shreg_n;
            cs_n_q   <= cs_n_n;
            sclk_q   <= sclk_n;
            din_q    <= din_n;
            busy_q   <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        half_n  = half_cnt;
        shreg_n = shreg;
        cs_n_n  = cs_n_q;
        sclk_n  = sclk_q;
        din_n   = din_q;
        busy_n  = busy_q;
        launch  = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    launch  = 1'b1;
                    shreg_n = {dac_val[6:0], 1'b0};
                    din_n   = dac_val[7];
                    cs_n_n  = 1'b0;
                    busy_n  = 1'b1;
                    div_n   = '0;
                    half_n  = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == SCLK_DIV - 8'd1) begin
                    div_n  = '0;
                    sclk_n = ~sclk_q;
                    half_n = half_cnt + 4'd1;
                    if (sclk_q) begin
                        // Falling edge: next bit, or end of frame after the 8th.
                        if (half_cnt == 4'd15) begin
                            cs_n_n  = 1'b1;
                            din_n   = 1'b0;
                            state_n = DONE;
                        end else begin
                            din_n   = shreg[7];
                            shreg_n = {shreg[6:0], 1'b0};
                        end
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            DONE: begin
                if (div_cnt == SCLK_DIV - 8'd1) begin
                    div_n   = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_din  = din_q;
    assign busy     = busy_q;

endmodule

// File: doc/dac_setpoint_ctrl.md
Name: dac_setpoint_ctrl

Overview:
- Generates the 8-bit DAC code from two push-buttons (up/down) and loads it into an external 8-bit serial DAC over a 3-wire link (CS_N/SCLK/DIN).
- Sits directly upstream of the 7-segment display driver: its dac_val output feeds that driver's dac_val input.
- Each debounced press steps the code by STEP, saturating at both ends.
- Every code change triggers a serial reload of the DAC.

Parameters:
- DEBOUNCE_CLK, 20'd1000000: clk cycles an input must be stable before the debounced level changes (10 ms at 100 MHz).
- STEP, 8'd1: increment/decrement amount per press.
- SCLK_DIV, 8'd4: clk cycles per SCLK half-period (H). Must be ≥1.
- REPEAT_DELAY, 26'd50000000: hold time before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_RATE, 26'd10000000: auto-repeat interval (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- btn_up  input  1  raw up button, active-high, asynchronous to clk
- btn_down  input  1  raw down button, active-high, asynchronous to clk
- dac_val  output  8  current DAC code, to the 7-seg display stage
- dac_cs_n  output  1  DAC chip select, active-low
- dac_sclk  output  1  DAC serial clock, idle low
- dac_din  output  1  DAC serial data, MSB first
- busy  output  1  high while a serial transfer is in progress

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values: dac_val=8'h00, dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0. Synchronisers, debounce counters and debounced levels are 0. pending=1, so 0x00 is sent once after reset release.
- A reset assertion mid-transfer aborts the transfer immediately, with outputs at their reset values.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter clears whenever the synced value equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CLK-1, the debounced level takes the synced value and the counter clears.
  - A press is a 0→1 transition of the debounced level, as a 1-cycle pulse.
- Code update, on the cycle after a press pulse:
  - Up only: dac_val = min(dac_val+STEP, 255). Compute in 9 bits, no wrap.
  - Down only: dac_val = max(dac_val-STEP, 0). No wrap.
  - Up and down pulses in the same cycle: no change.
  - A saturated press, where the value does not change, does not set pending.
  - Any actual change sets pending.
- Transfer FSM states:
  - IDLE: busy=0, cs_n=1, sclk=0. If pending: latch shift register = dac_val, clear pending, cs_n=0, din=bit7, busy=1, go to SHIFT.
  - SHIFT: sclk toggles every H cycles, with the first rise H cycles after cs_n falls. din updates on each sclk falling edge to the next bit. The DAC samples on rising edges. After the 8th falling edge (16·H cycles in SHIFT), cs_n=1, din=0, go to DONE.
  - DONE: hold cs_n=1 for H cycles, then go to IDLE. busy=0 on entry to IDLE.
- Transfer value and re-triggering:
  - The transmitted value is the one latched at the start of the transfer.
  - Changes during SHIFT/DONE set pending, and a new transfer starts on the first IDLE cycle.
  - Multiple changes during one transfer coalesce into a single retransfer of the latest value.
- Latency: dac_val changes exactly 1 cycle after the press pulse. cs_n falls 1 cycle after pending is seen in IDLE.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While a debounced level stays high, after REPEAT_DELAY cycles from its press pulse an extra press pulse is generated every REPEAT_RATE cycles.
  - Repeat timing restarts on release.
  - If both buttons are held, no repeats are generated.
  - Saturation rules are unchanged.
- Undefined: exactly one step per press. The repeat counters and parameters are unused and absent from the RTL.

Test Plan (DEBOUNCE_CLK=8, SCLK_DIV=2, STEP=1 unless stated):
- Release reset → one transfer of 0x00: cs_n low for 16·2=32 cycles, 8 sclk rising edges, din all 0. busy high for the full transfer plus 2 DONE cycles. dac_val=0x00.
- Press btn_up with 3 cycles of bounce, then hold stable for 20 cycles → exactly one increment: dac_val 0x00→0x01. One transfer sampled as 0x01 (din = 0,0,0,0,0,0,0,1 on rising edges).
- Preload to 0xFF via 255 presses, then press up → dac_val stays 0xFF and no transfer starts. Press down → 0xFE, transfer sampled as 0xFE.
- At dac_val=0x00, press down → stays 0x00, no transfer. With STEP=8'd10 at 0xFA, press up → 0xFF, not wrapped.
- Three up presses completing during one transfer → current transfer finishes unchanged, then exactly one further transfer of the final value (old+3).
- Assert rst in the middle of SHIFT → cs_n=1, sclk=0, din=0 and dac_val=0x00 immediately. After release, one 0x00 transfer.
- With AUTO_REPEAT_EN, REPEAT_DELAY=40, REPEAT_RATE=10: hold up for 100 cycles after debounce → increments at press, +40, +50, +60 … and dac_val reaches 0x07.
